// File: rtl/p2_link_tx.sv
// Player-2 link serial transmitter: frames the synchronized button levels onto one wire on change or keepalive.
// Optional even parity bit after d4 when P2_LINK_PARITY_EN is defined.
module p2_link_tx #(
   parameter int CLKS_PER_BIT   = 10000,
   parameter int GAP_BITS       = 2,
   parameter int KEEPALIVE_BITS = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [4:0] buttons,
   output logic       tx_out,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] frames_sent
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = $clog2(GAP_BITS + 1);
   localparam int KW = $clog2(KEEPALIVE_BITS + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
   localparam logic [KW-1:0] KA_FULL  = KW'(KEEPALIVE_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef P2_LINK_PARITY_EN
      PARITY,
`endif
      STOP,
      GAP
   } state_t;

   state_t        state;
   logic [4:0]    sync1;
   logic [4:0]    btn_s;
   logic [4:0]    last_sent;
   logic [4:0]    shreg;
   logic [2:0]    idx;
   logic [CW-1:0] bit_cnt;
   logic [CW-1:0] ka_pre;
   logic [GW-1:0] gap_cnt;
   logic [KW-1:0] ka_cnt;
`ifdef P2_LINK_PARITY_EN
   logic          par;
`endif
   logic          line;
   logic          bit_tick;
   logic          ka_tick;
   logic          send_now;

   assign bit_tick = (bit_cnt == BIT_LAST);
   assign ka_tick  = (ka_pre == BIT_LAST);
   assign send_now = enable && ((btn_s != last_sent) || (ka_cnt == KA_FULL));

   // Line level for the current state; registered into tx_out one clk later.
   always_comb begin
      line = 1'b1;
      case (state)
         START:  line = 1'b0;
         DATA:   line = shreg[0];
`ifdef P2_LINK_PARITY_EN
         PARITY: line = par;
`endif
         default: line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sync1       <= '0;
         btn_s       <= '0;
         last_sent   <= '0;
         shreg       <= '0;
         idx         <= '0;
         bit_cnt     <= '0;
         ka_pre      <= '0;
         gap_cnt     <= '0;
         ka_cnt      <= '0;
`ifdef P2_LINK_PARITY_EN
         par         <= 1'b0;
`endif
         tx_out      <= 1'b1;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frames_sent <= '0;
      end else begin
         sync1      <= buttons;
         btn_s      <= sync1;
         ka_pre     <= ka_tick ? '0 : ka_pre + CW'(1);
         tx_out     <= line;
         busy       <= (state != IDLE);
         frame_done <= 1'b0;
         bit_cnt    <= (state == IDLE || bit_tick) ? '0 : bit_cnt + CW'(1);

         case (state)
            IDLE: begin
               if (ka_tick && ka_cnt != KA_FULL)
                  ka_cnt <= ka_cnt + KW'(1);
               // A change and a due keepalive collapse into this single decision.
               if (send_now) begin
                  state     <= START;
                  shreg     <= btn_s;
                  last_sent <= btn_s;
                  ka_cnt    <= '0;
`ifdef P2_LINK_PARITY_EN
                  par       <= ^btn_s;
`endif
               end
            end
            START: begin
               if (bit_tick) begin
                  state <= DATA;
                  idx   <= '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shreg <= {1'b0, shreg[4:1]};
                  if (idx == 3'd4)
`ifdef P2_LINK_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  else
                     idx <= idx + 3'd1;
               end
            end
`ifdef P2_LINK_PARITY_EN
            PARITY: begin
               if (bit_tick)
                  state <= STOP;
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  state       <= GAP;
                  gap_cnt     <= '0;
                  frame_done  <= 1'b1;
                  frames_sent <= frames_sent + 8'd1;
               end
            end
            GAP: begin
               if (bit_tick) begin
                  if (gap_cnt == GAP_LAST)
                     state <= IDLE;
                  else
                     gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_p2_link_tx.sv
// Directed bench for p2_link_tx with CLKS_PER_BIT=4, GAP_BITS=2, KEEPALIVE_BITS=8.
// Frames are captured cycle by cycle on tx_out and compared against hand-written expectations.
module tb_p2_link_tx;
   localparam int CPB = 4;
   localparam int GB  = 2;
   localparam int KA  = 8;
`ifdef P2_LINK_PARITY_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif
   localparam int FRAME_CYC = NB * CPB;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [4:0] buttons;
   logic       tx_out;
   logic       busy;
   logic       frame_done;
   logic [7:0] frames_sent;

   int tests = 0;
   int fails = 0;

   p2_link_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GB), .KEEPALIVE_BITS(KA)) dut (
      .clk(clk), .reset(reset), .enable(enable), .buttons(buttons),
      .tx_out(tx_out), .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [4:0] btn;
      logic [4:0] exp_d;   // data bits in transmit order, d0 in bit 0
      logic       exp_par;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Steps until tx_out is low; the sample that sees it is index 0 of the frame.
   task automatic wait_start(input string name, input int max, input int exp_lat);
      int  k;
      logic found;
      k = 0;
      found = 1'b0;
      while (k < max && !found) begin
         step();
         k++;
         if (tx_out === 1'b0) found = 1'b1;
      end
      check($sformatf("%s_start_seen", name), found, 1);
      if (exp_lat > 0)
         check($sformatf("%s_latency", name), k, exp_lat);
   endtask

   task automatic check_frame(input string name, input logic [4:0] exp_d, input logic exp_par,
                              input logic [7:0] exp_cnt, input int chg_at, input logic [4:0] chg_val,
                              input int en_at);
      logic [7:0] bits;
      logic stable, busy_ok;
      int fd_pos, fd_cnt;
      bits = '1;
      stable = 1'b1;
      busy_ok = 1'b1;
      fd_pos = -1;
      fd_cnt = 0;
      for (int s = 0; s < FRAME_CYC; s++) begin
         if (s > 0) step();
         if (s == chg_at) buttons = chg_val;
         if (s == en_at) enable = 1'b0;
         if (s % CPB == 0) bits[s / CPB] = tx_out;
         else if (tx_out !== bits[s / CPB]) stable = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_pos = s;
         end
      end
      check($sformatf("%s_startbit", name), bits[0], 0);
      check($sformatf("%s_data", name), bits[5:1], exp_d);
`ifdef P2_LINK_PARITY_EN
      check($sformatf("%s_parity", name), bits[6], exp_par);
`endif
      check($sformatf("%s_stopbit", name), bits[NB-1], 1);
      check($sformatf("%s_bit_width", name), stable, 1);
      check($sformatf("%s_busy", name), busy_ok, 1);
      check($sformatf("%s_done_count", name), fd_cnt, 1);
      check($sformatf("%s_done_pos", name), fd_pos, FRAME_CYC - 1);
      check($sformatf("%s_frames_sent", name), frames_sent, exp_cnt);
      $display("[TB] frame %s: line=%b exp_d=%b exp_par=%b frames_sent=%0d",
               name, bits, exp_d, exp_par, frames_sent);
   endtask

   // Gap is GB bit periods of idle-high; busy drops on the sample after it.
   task automatic after_frame(input string name);
      int n;
      logic line_ok;
      n = 0;
      line_ok = 1'b1;
      do begin
         step();
         n++;
         if (tx_out !== 1'b1) line_ok = 1'b0;
      end while (busy === 1'b1 && n < 40);
      check($sformatf("%s_gap_len", name), n, GB * CPB + 1);
      check($sformatf("%s_gap_line", name), line_ok, 1);
   endtask

   task automatic quiet(input string name, input int cycles);
      logic ok;
      ok = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         step();
         if (tx_out !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      check($sformatf("%s_quiet", name), ok, 1);
   endtask

   initial begin
      int pulses, timeouts, dbl, n;

      vecs[0] = '{5'b11111, 5'b11111, 1'b1, 8'd3};
      vecs[1] = '{5'b01010, 5'b01010, 1'b0, 8'd4};
      vecs[2] = '{5'b10001, 5'b10001, 1'b0, 8'd5};
      vecs[3] = '{5'b00100, 5'b00100, 1'b1, 8'd6};
      vecs[4] = '{5'b01100, 5'b01100, 1'b0, 8'd7};

      reset = 1'b1;
      enable = 1'b0;
      buttons = 5'b00000;
      step();
      step();
      check("rst_tx_out", tx_out, 1);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frames_sent", frames_sent, 0);

      // Keepalive: 8 bit periods (32 clk) in IDLE, one compare clk, then the output register.
      enable = 1'b1;
      reset = 1'b0;
      quiet("pre_keepalive", 33);
      wait_start("keepalive", 10, 1);
      check_frame("keepalive", 5'b00000, 1'b0, 8'd1, -1, 5'b00000, -1);
      after_frame("keepalive");

      // 2 clk synchronizer + 1 clk compare + output register: tx_out low 4 clk after the edge.
      step(); step(); step(); step();
      buttons = 5'b10110;
      wait_start("b10110", 20, 4);
      check_frame("b10110", 5'b10110, 1'b1, 8'd2, -1, 5'b00000, -1);
      after_frame("b10110");

      for (int i = 0; i < 5; i++) begin
         buttons = vecs[i].btn;
         wait_start($sformatf("vec%0d", i), 100, -1);
         check_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_par, vecs[i].exp_cnt,
                     -1, 5'b00000, -1);
         after_frame($sformatf("vec%0d", i));
      end

      // Change during d1 must not disturb the frame and triggers a back-to-back frame.
      buttons = 5'b11010;
      wait_start("toggle_a", 100, -1);
      check_frame("toggle_a", 5'b11010, 1'b1, 8'd8, 2 * CPB + 1, 5'b00001, -1);
      after_frame("toggle_a");
      step();
      check("toggle_restart", tx_out, 0);
      if (tx_out !== 1'b0) wait_start("toggle_b", 100, -1);
      check_frame("toggle_b", 5'b00001, 1'b1, 8'd9, -1, 5'b00000, -1);
      after_frame("toggle_b");

      // Enable dropped during d2: frame and gap complete, then nothing until re-enabled.
      buttons = 5'b01101;
      wait_start("en_drop", 100, -1);
      check_frame("en_drop", 5'b01101, 1'b1, 8'd10, -1, 5'b00000, 3 * CPB + 1);
      after_frame("en_drop");
      buttons = 5'b10010;
      quiet("disabled", 60);
      enable = 1'b1;
      wait_start("reenable", 20, 2);
      check_frame("reenable", 5'b10010, 1'b0, 8'd11, -1, 5'b00000, -1);
      after_frame("reenable");
      quiet("single_frame", 25);

      // Reset during d3 aborts the frame at once.
      buttons = 5'b00111;
      wait_start("abort", 100, -1);
      for (int c = 0; c < 4 * CPB + 1; c++) step();
      reset = 1'b1;
      #1;
      check("abort_tx_out", tx_out, 1);
      check("abort_busy", busy, 0);
      check("abort_frames_sent", frames_sent, 0);
      step();
      step();
      reset = 1'b0;
      wait_start("post_reset", 20, 4);
      check_frame("post_reset", 5'b00111, 1'b1, 8'd1, -1, 5'b00000, -1);
      after_frame("post_reset");

      // 256 frames from a fresh reset: counter wraps to 0, frame_done always one clk wide.
      reset = 1'b1;
      buttons = 5'b00000;
      step();
      reset = 1'b0;
      pulses = 0;
      timeouts = 0;
      dbl = 0;
      for (int i = 0; i < 256; i++) begin
         buttons = (i % 2 == 0) ? 5'b11111 : 5'b00000;
         n = 0;
         do begin
            step();
            n++;
         end while (frame_done !== 1'b1 && n < 200);
         if (frame_done === 1'b1) pulses++;
         else timeouts++;
         if (i == 254) check("wrap_255", frames_sent, 255);
         step();
         if (frame_done !== 1'b0) dbl++;
      end
      $display("[TB] wrap run: pulses=%0d timeouts=%0d double=%0d frames_sent=%0d",
               pulses, timeouts, dbl, frames_sent);
      check("wrap_pulses", pulses, 256);
      check("wrap_timeouts", timeouts, 0);
      check("wrap_double_pulse", dbl, 0);
      check("wrap_zero", frames_sent, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
